l2_dual_port_arbiter: RTL and testbench
=======================================

L2_DUAL_PORT_ARBITER -- requirements
Module: l2_dual_port_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2: number of requesters.
REQ-002 SHALL have parameter AddrWidth, default 48: requester address width.
REQ-003 SHALL have parameter DataWidth, default 64: data width; byte enables are DataWidth/8 bits.
REQ-004 SHALL have parameter L2Base, default 'h78000000: port 0 base address.
REQ-005 SHALL have parameter L2PortSize, default 'h00020000: per-port window size; port 1 base = L2Base + L2PortSize.
REQ-006 SHALL have port clk_i, input, 1: single clock; all logic rising-edge.
REQ-007 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have ports req_i, we_i (input, NumReq) and addr_i, wdata_i, be_i (input, NumReq x AddrWidth/DataWidth/DataWidth/8): requester requests.
REQ-009 SHALL have ports gnt_o, rvalid_o, err_o (output, NumReq) and rdata_o (output, NumReq x DataWidth): requester responses.
REQ-010 SHALL have ports mem_req_o, mem_we_o (output, 2), mem_addr_o (output, 2x32), mem_wdata_o (output, 2xDataWidth), mem_be_o (output, 2xDataWidth/8): L2 port requests.
REQ-011 SHALL have ports mem_gnt_i, mem_rvalid_i (input, 2) and mem_rdata_i (input, 2xDataWidth): L2 port responses.

Function
REQ-012 SHALL compute off = addr_i - L2Base, unsigned modulo 2^AddrWidth; off < L2PortSize -> port 0; L2PortSize <= off < 2*L2PortSize -> port 1; otherwise, including addr_i < L2Base, -> error.
REQ-013 SHALL drive mem_addr_o[p] = off - p*L2PortSize, truncated to 32 bits.
REQ-014 SHALL keep per-requester FSM: IDLE, WAIT_P0, WAIT_P1, ERR.
REQ-015 IDLE -> WAIT_Pp when req_i is high, the decode selects port p, the requester wins arbitration for p and mem_gnt_i[p] is high; gnt_o pulses combinationally that cycle.
REQ-016 IDLE -> ERR when req_i is high and the decode returns error; gnt_o SHALL be high the same cycle, with no mem_req_o.
REQ-017 ERR -> IDLE after exactly 1 cycle with rvalid_o=1, err_o=1, rdata_o=0.
REQ-018 WAIT_Pp -> IDLE on mem_rvalid_i[p]; same cycle rvalid_o=1, err_o=0, rdata_o=mem_rdata_i[p]; requests held during WAIT SHALL NOT be granted.
REQ-019 Earliest next gnt_o for a requester SHALL be the cycle after its rvalid_o; at most one outstanding transaction per requester.
REQ-020 Per port: round-robin among IDLE requesters targeting it; a 1-cycle delay token of NumReq bits (priority pointer) SHALL advance to the requester after the winner only when mem_req_o & mem_gnt_i; no grant -> pointer unchanged.
REQ-021 mem_req_o[p] and payload SHALL come combinationally from the current winner; payload SHALL be stable while mem_req_o is high without gnt, provided requester holds inputs (requester obligation: hold until gnt_o).
REQ-022 SHALL keep per-port ID FIFO, depth NumReq, push on handshake, pop on mem_rvalid_i, routing rvalid to the head ID; mem_rvalid_i with empty FIFO SHALL be ignored (no rvalid_o).
REQ-023 Simultaneous push and pop on a port SHALL both take effect; occupancy unchanged.
REQ-024 Both ports SHALL operate independently in the same cycle; two requesters to different ports SHALL both be granted.
REQ-025 rvalid_o and gnt_o SHALL never both be high for a requester in the same cycle.

Reset
REQ-026 While rst_i is high at a clock edge: all FSMs -> IDLE, FIFOs empty, priority pointers -> requester 0.
REQ-027 During and after reset, until new requests: gnt_o, rvalid_o, err_o, mem_req_o = 0; rdata_o = 0.
REQ-028 Reset mid-transaction SHALL drop outstanding IDs; later mem_rvalid_i for them SHALL be ignored.

Verification
REQ-029 Single read: req0 addr 'h78000010, mem_gnt_i=1, rvalid 2 cycles later with 'hDEAD -> mem_addr_o[0]='h10, gnt_o[0] same cycle, rvalid_o[0] with rdata 'hDEAD.
REQ-030 Port 1 decode: addr 'h78020008 -> mem_req_o[1], mem_addr_o[1]='h8; addr 'h78040000 and 'h77FFFFF8 -> gnt, then err_o=1 next cycle, no mem_req_o.
REQ-031 Contention: both requesters target port 0 every cycle, mem_gnt_i=1, rvalid 1 cycle after handshake -> grants alternate 0,1,0,1; none starved.
REQ-032 Parallel: req0 -> port 0, req1 -> port 1 same cycle -> both granted same cycle; responses routed correctly.
REQ-033 Backpressure: mem_gnt_i[0]=0 for 3 cycles -> mem_req_o held, payload stable, pointer unchanged, gnt_o low until mem_gnt_i rises.
REQ-034 Reset mid-WAIT: rst_i pulsed in WAIT_P0, then mem_rvalid_i[0] -> no rvalid_o; next request granted normally.

Source files
------------

// File: rtl/l2_dual_port_arbiter.sv
// Connects NumReq requesters to two L2 SRAM ports selected by address window.
// Each port has its own round-robin arbiter and a FIFO of in-flight requester IDs.
// An address outside both windows is granted and then completes with an error response.
module l2_dual_port_arbiter #(
    parameter int unsigned NumReq     = 2,
    parameter int unsigned AddrWidth  = 48,
    parameter int unsigned DataWidth  = 64,
    parameter logic [63:0] L2Base     = 64'h7800_0000,
    parameter logic [63:0] L2PortSize = 64'h0002_0000
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumReq-1:0]                  req_i,
    input  logic [NumReq-1:0]                  we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0] be_i,
    output logic [NumReq-1:0]                  gnt_o,
    output logic [NumReq-1:0]                  rvalid_o,
    output logic [NumReq-1:0]                  err_o,
    output logic [NumReq-1:0][DataWidth-1:0]   rdata_o,
    output logic [1:0]                         mem_req_o,
    output logic [1:0]                         mem_we_o,
    output logic [1:0][31:0]                   mem_addr_o,
    output logic [1:0][DataWidth-1:0]          mem_wdata_o,
    output logic [1:0][DataWidth/8-1:0]        mem_be_o,
    input  logic [1:0]                         mem_gnt_i,
    input  logic [1:0]                         mem_rvalid_i,
    input  logic [1:0][DataWidth-1:0]          mem_rdata_i
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = $clog2(NumReq + 1);
    localparam logic [AddrWidth-1:0] BaseA  = AddrWidth'(L2Base);
    localparam logic [AddrWidth-1:0] SizeA  = AddrWidth'(L2PortSize);
    localparam logic [AddrWidth-1:0] Size2A = AddrWidth'(L2PortSize << 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_P0, S_WAIT_P1, S_ERR} state_e;

    state_e                              r_state [NumReq];
    logic [1:0][NumReq-1:0]              r_ptr;
    logic [1:0][NumReq-1:0][IdxW-1:0]    r_fifo;
    logic [1:0][IdxW-1:0]                r_rd;
    logic [1:0][IdxW-1:0]                r_wr;
    logic [1:0][CntW-1:0]                r_cnt;

    logic [NumReq-1:0][AddrWidth-1:0]    w_off;
    logic [NumReq-1:0]                   w_to_p0;
    logic [NumReq-1:0]                   w_to_p1;
    logic [NumReq-1:0]                   w_to_err;
    logic [NumReq-1:0]                   w_idle;
    logic [1:0][NumReq-1:0]              w_cand;
    logic [1:0]                          w_found;
    logic [1:0][IdxW-1:0]                w_win;
    logic [1:0][IdxW-1:0]                w_ptr_idx;
    logic [1:0]                          w_hs;
    logic [1:0]                          w_pop;
    logic [1:0][IdxW-1:0]                w_head;

    // Wrapping increment for FIFO pointers and the round-robin successor.
    function automatic logic [IdxW-1:0] f_inc(input logic [IdxW-1:0] v);
        return (v == IdxW'(NumReq - 1)) ? '0 : v + IdxW'(1);
    endfunction

    // Address decode: offset from the L2 base selects port 0, port 1 or error.
    always_comb begin
        w_off    = '0;
        w_to_p0  = '0;
        w_to_p1  = '0;
        w_to_err = '0;
        w_idle   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            w_off[i]    = addr_i[i] - BaseA;
            w_to_p0[i]  = (w_off[i] < SizeA);
            w_to_p1[i]  = !w_to_p0[i] && (w_off[i] < Size2A);
            w_to_err[i] = !w_to_p0[i] && !w_to_p1[i];
            w_idle[i]   = (r_state[i] == S_IDLE);
        end
    end

    // Per-port round-robin pick starting at the priority pointer; winner drives the port.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        w_cand      = '0;
        w_found     = '0;
        w_win       = '0;
        w_ptr_idx   = '0;
        w_hs        = '0;
        mem_req_o   = '0;
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                w_cand[p][i] = req_i[i] && w_idle[i] && ((p == 0) ? w_to_p0[i] : w_to_p1[i]);
                if (r_ptr[p][i]) w_ptr_idx[p] = IdxW'(i);
            end
            for (int unsigned k = 0; k < NumReq; k++) begin
                idx = 32'(w_ptr_idx[p]) + k;
                if (idx >= NumReq) idx = idx - NumReq;
                if (!w_found[p] && w_cand[p][IdxW'(idx)]) begin
                    w_found[p] = 1'b1;
                    w_win[p]   = IdxW'(idx);
                end
            end
            mem_req_o[p] = w_found[p] && !rst_i;
            if (w_found[p]) begin
                mem_we_o[p]    = we_i[w_win[p]];
                mem_addr_o[p]  = 32'(w_off[w_win[p]] - ((p == 1) ? SizeA : '0));
                mem_wdata_o[p] = wdata_i[w_win[p]];
                mem_be_o[p]    = be_i[w_win[p]];
            end
            w_hs[p] = mem_req_o[p] && mem_gnt_i[p];
        end
    end

    // Response FIFO head: an rvalid with no outstanding ID is dropped.
    always_comb begin
        w_pop  = '0;
        w_head = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            w_pop[p]  = mem_rvalid_i[p] && (r_cnt[p] != '0);
            w_head[p] = r_fifo[p][r_rd[p]];
        end
    end

    // Requester-side grant and response outputs, all silenced during reset.
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (!rst_i) begin
                if (w_idle[i] && req_i[i] && w_to_err[i]) gnt_o[i] = 1'b1;
                for (int unsigned p = 0; p < 2; p++) begin
                    if (w_hs[p] && (w_win[p] == IdxW'(i))) gnt_o[i] = 1'b1;
                end
                case (r_state[i])
                    S_WAIT_P0: if (w_pop[0] && (w_head[0] == IdxW'(i))) begin
                        rvalid_o[i] = 1'b1;
                        rdata_o[i]  = mem_rdata_i[0];
                    end
                    S_WAIT_P1: if (w_pop[1] && (w_head[1] == IdxW'(i))) begin
                        rvalid_o[i] = 1'b1;
                        rdata_o[i]  = mem_rdata_i[1];
                    end
                    S_ERR: begin
                        rvalid_o[i] = 1'b1;
                        err_o[i]    = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Requester FSMs, priority pointers and ID FIFOs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumReq; i++) r_state[i] <= S_IDLE;
            for (int unsigned p = 0; p < 2; p++) begin
                r_ptr[p] <= NumReq'(1);
                r_rd[p]  <= '0;
                r_wr[p]  <= '0;
                r_cnt[p] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                case (r_state[i])
                    S_IDLE: if (gnt_o[i]) begin
                        r_state[i] <= w_to_err[i] ? S_ERR : (w_to_p0[i] ? S_WAIT_P0 : S_WAIT_P1);
                    end
                    S_WAIT_P0, S_WAIT_P1: if (rvalid_o[i]) r_state[i] <= S_IDLE;
                    default: r_state[i] <= S_IDLE;
                endcase
            end
            for (int unsigned p = 0; p < 2; p++) begin
                if (w_hs[p]) begin
                    r_fifo[p][r_wr[p]] <= w_win[p];
                    r_wr[p]            <= f_inc(r_wr[p]);
                    r_ptr[p]           <= NumReq'(1) << f_inc(w_win[p]);
                end
                if (w_pop[p]) r_rd[p] <= f_inc(r_rd[p]);
                if (w_hs[p] && !w_pop[p]) begin
                    r_cnt[p] <= r_cnt[p] + CntW'(1);
                end else if (!w_hs[p] && w_pop[p]) begin
                    r_cnt[p] <= r_cnt[p] - CntW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_dual_port_arbiter.sv
// Bench for l2_dual_port_arbiter: directed scenarios with literal expectations plus a
// transaction-level model (queues of outstanding IDs) compared every cycle.
module tb_l2_dual_port_arbiter;

    localparam int unsigned    AW   = 48;
    localparam int unsigned    DW   = 64;
    localparam int unsigned    BW   = 8;
    localparam longint unsigned BASE = 64'h7800_0000;
    localparam longint unsigned SIZE = 64'h0002_0000;
    localparam longint unsigned MASK = 64'hFFFF_FFFF_FFFF;

    logic                 clk;
    logic                 rst_i;
    logic [1:0]           req_i, we_i;
    logic [1:0][AW-1:0]   addr_i;
    logic [1:0][DW-1:0]   wdata_i;
    logic [1:0][BW-1:0]   be_i;
    logic [1:0]           gnt_o, rvalid_o, err_o;
    logic [1:0][DW-1:0]   rdata_o;
    logic [1:0]           mem_req_o, mem_we_o;
    logic [1:0][31:0]     mem_addr_o;
    logic [1:0][DW-1:0]   mem_wdata_o;
    logic [1:0][BW-1:0]   mem_be_o;
    logic [1:0]           mem_gnt_i, mem_rvalid_i;
    logic [1:0][DW-1:0]   mem_rdata_i;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;

    // model state
    int   m_out[2];
    bit   m_err[2];
    int   m_rr[2];
    int   q0[$];
    int   q1[$];
    // model expectations for the current cycle
    int          e_port[2];
    int          e_win[2];
    int          e_head[2];
    bit  [1:0]   e_mreq, e_gnt, e_rv, e_err;
    logic [63:0] e_rdata[2];

    logic [1:0] hs_seen;
    bit   [1:0] auto_rsp;

    l2_dual_port_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .be_i(be_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned f_off(input logic [AW-1:0] a);
        return (64'(a) - BASE) & MASK;
    endfunction

    function automatic int f_port(input logic [AW-1:0] a);
        longint unsigned o;
        o = f_off(a);
        if (o < SIZE) return 0;
        if (o < 2 * SIZE) return 1;
        return 2;
    endfunction

    function automatic bit m_idle(input int r);
        return (m_out[r] < 0) && !m_err[r];
    endfunction

    // What the outputs must be this cycle, from the transaction rules.
    task automatic model_eval();
        for (int r = 0; r < 2; r++) e_port[r] = f_port(addr_i[r]);
        for (int p = 0; p < 2; p++) begin
            e_win[p] = -1;
            for (int k = 0; k < 2; k++) begin
                int c;
                c = (m_rr[p] + k) % 2;
                if (e_win[p] < 0 && req_i[c] && m_idle(c) && e_port[c] == p) e_win[p] = c;
            end
            e_mreq[p] = !rst_i && (e_win[p] >= 0);
        end
        e_head[0] = (q0.size() > 0) ? q0[0] : -1;
        e_head[1] = (q1.size() > 0) ? q1[0] : -1;
        e_gnt = '0; e_rv = '0; e_err = '0;
        for (int r = 0; r < 2; r++) begin
            e_rdata[r] = '0;
            if (!rst_i) begin
                if (req_i[r] && m_idle(r) && e_port[r] == 2) e_gnt[r] = 1'b1;
                if (e_port[r] < 2 && e_win[e_port[r]] == r && mem_gnt_i[e_port[r]]) e_gnt[r] = 1'b1;
                if (m_err[r]) begin
                    e_rv[r]  = 1'b1;
                    e_err[r] = 1'b1;
                end
                for (int p = 0; p < 2; p++) begin
                    if (mem_rvalid_i[p] && e_head[p] == r) begin
                        e_rv[r]    = 1'b1;
                        e_rdata[r] = mem_rdata_i[p];
                    end
                end
            end
        end
    endtask

    // Advance the model across a clock edge.
    task automatic model_update();
        if (rst_i) begin
            m_out = '{-1, -1};
            m_err = '{0, 0};
            m_rr  = '{0, 0};
            q0.delete();
            q1.delete();
            return;
        end
        if (mem_rvalid_i[0] && e_head[0] >= 0) begin m_out[e_head[0]] = -1; void'(q0.pop_front()); end
        if (mem_rvalid_i[1] && e_head[1] >= 0) begin m_out[e_head[1]] = -1; void'(q1.pop_front()); end
        for (int r = 0; r < 2; r++) m_err[r] = 1'b0;
        for (int r = 0; r < 2; r++) begin
            if (e_gnt[r]) begin
                if (e_port[r] == 2) m_err[r] = 1'b1;
                else begin
                    m_out[r] = e_port[r];
                    if (e_port[r] == 0) q0.push_back(r); else q1.push_back(r);
                end
            end
        end
        for (int p = 0; p < 2; p++) if (e_mreq[p] && mem_gnt_i[p]) m_rr[p] = (e_win[p] + 1) % 2;
    endtask

    // Per-cycle compare against the model, sampled mid-cycle.
    initial begin
        m_out = '{-1, -1};
        m_err = '{0, 0};
        m_rr  = '{0, 0};
        hs_seen = '0;
        forever begin
            @(negedge clk);
            #3;
            model_eval();
            chk("gnt_o", 64'(gnt_o), 64'(e_gnt));
            chk("rvalid_o", 64'(rvalid_o), 64'(e_rv));
            chk("err_o", 64'(err_o), 64'(e_err));
            chk("mem_req_o", 64'(mem_req_o), 64'(e_mreq));
            for (int r = 0; r < 2; r++)
                if (e_rv[r]) chk($sformatf("rdata_o[%0d]", r), rdata_o[r], e_rdata[r]);
            for (int p = 0; p < 2; p++) begin
                if (e_mreq[p]) begin
                    chk($sformatf("mem_addr_o[%0d]", p), 64'(mem_addr_o[p]),
                        64'(32'(f_off(addr_i[e_win[p]]) - ((p == 1) ? SIZE : 64'd0))));
                    chk($sformatf("mem_we_o[%0d]", p), 64'(mem_we_o[p]), 64'(we_i[e_win[p]]));
                    chk($sformatf("mem_wdata_o[%0d]", p), mem_wdata_o[p], wdata_i[e_win[p]]);
                    chk($sformatf("mem_be_o[%0d]", p), 64'(mem_be_o[p]), 64'(be_i[e_win[p]]));
                end
            end
            hs_seen = mem_req_o & mem_gnt_i;
            @(posedge clk);
            model_update();
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    // Advance one cycle; the auto responder answers a handshake on the following cycle.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            if (auto_rsp[p]) begin
                mem_rvalid_i[p] = hs_seen[p];
                mem_rdata_i[p]  = 64'hC0DE_0000 + 64'(cyc_n);
            end
        end
        cyc_n++;
    endtask

    task automatic set_req(input int r, input bit rq, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
        req_i[r]   = rq;
        we_i[r]    = we;
        addr_i[r]  = a;
        wdata_i[r] = d;
        be_i[r]    = be;
    endtask

    initial begin
        rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
        mem_gnt_i = '0; mem_rvalid_i = '0; mem_rdata_i = '0; auto_rsp = '0;
        @(negedge clk);
        #2;
        chk("reset gnt_o", 64'(gnt_o), 64'd0);
        chk("reset rvalid_o", 64'(rvalid_o), 64'd0);
        chk("reset mem_req_o", 64'(mem_req_o), 64'd0);
        chk("reset rdata_o[0]", rdata_o[0], 64'd0);
        chk("reset rdata_o[1]", rdata_o[1], 64'd0);
        cyc();
        rst_i = 1'b0;

        // contention on port 0, responses one cycle after each handshake
        mem_gnt_i = 2'b11;
        auto_rsp[0] = 1'b1;
        set_req(0, 1, 0, 48'h7800_0040, '0, '0);
        set_req(1, 1, 0, 48'h7800_0080, '0, '0);
        for (int c = 0; c < 4; c++) begin
            #2;
            chk($sformatf("rr grant %0d", c), 64'(gnt_o), (c % 2 == 0) ? 64'd1 : 64'd2);
            cyc();
        end
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, '0, '0, '0);
        cyc();
        auto_rsp[0] = 1'b0;
        mem_rvalid_i = '0;

        // single read on port 0
        set_req(0, 1, 0, 48'h7800_0010, '0, '0);
        #2;
        chk("read mem_req_o", 64'(mem_req_o), 64'd1);
        chk("read mem_addr_o[0]", 64'(mem_addr_o[0]), 64'h10);
        chk("read gnt_o", 64'(gnt_o), 64'd1);
        cyc();
        set_req(0, 0, 0, '0, '0, '0);
        cyc();
        mem_rvalid_i[0] = 1'b1; mem_rdata_i[0] = 64'hDEAD;
        #2;
        chk("read rvalid_o", 64'(rvalid_o), 64'd1);
        chk("read rdata_o[0]", rdata_o[0], 64'hDEAD);
        cyc();
        mem_rdata_i[0] = 64'hBEEF;
        #2;
        chk("stray rvalid ignored", 64'(rvalid_o), 64'd0);
        cyc();
        mem_rvalid_i = '0;

        // port 1 decode, then out-of-window errors above and below
        set_req(0, 1, 0, 48'h7802_0008, '0, '0);
        #2;
        chk("p1 mem_req_o", 64'(mem_req_o), 64'd2);
        chk("p1 mem_addr_o[1]", 64'(mem_addr_o[1]), 64'h8);
        chk("p1 gnt_o", 64'(gnt_o), 64'd1);
        cyc();
        set_req(0, 0, 0, '0, '0, '0);
        cyc();
        mem_rvalid_i[1] = 1'b1; mem_rdata_i[1] = 64'h1234;
        #2;
        chk("p1 rvalid_o", 64'(rvalid_o), 64'd1);
        chk("p1 rdata_o[0]", rdata_o[0], 64'h1234);
        cyc();
        mem_rvalid_i = '0;
        set_req(1, 1, 0, 48'h7804_0000, '0, '0);
        #2;
        chk("hi err gnt_o", 64'(gnt_o), 64'd2);
        chk("hi err mem_req_o", 64'(mem_req_o), 64'd0);
        cyc();
        set_req(1, 0, 0, '0, '0, '0);
        #2;
        chk("hi err err_o", 64'(err_o), 64'd2);
        chk("hi err rvalid_o", 64'(rvalid_o), 64'd2);
        chk("hi err rdata_o[1]", rdata_o[1], 64'd0);
        cyc();
        set_req(0, 1, 0, 48'h77FF_FFF8, '0, '0);
        #2;
        chk("lo err gnt_o", 64'(gnt_o), 64'd1);
        chk("lo err mem_req_o", 64'(mem_req_o), 64'd0);
        cyc();
        set_req(0, 0, 0, '0, '0, '0);
        #2;
        chk("lo err err_o", 64'(err_o), 64'd1);
        cyc();

        // both ports in the same cycle
        set_req(0, 1, 0, 48'h7800_0100, '0, '0);
        set_req(1, 1, 1, 48'h7802_0200, 64'h1122_3344_5566_7788, 8'hF0);
        #2;
        chk("par gnt_o", 64'(gnt_o), 64'd3);
        chk("par mem_req_o", 64'(mem_req_o), 64'd3);
        chk("par mem_addr_o[0]", 64'(mem_addr_o[0]), 64'h100);
        chk("par mem_addr_o[1]", 64'(mem_addr_o[1]), 64'h200);
        chk("par mem_we_o", 64'(mem_we_o), 64'd2);
        chk("par mem_wdata_o[1]", mem_wdata_o[1], 64'h1122_3344_5566_7788);
        chk("par mem_be_o[1]", 64'(mem_be_o[1]), 64'hF0);
        cyc();
        set_req(0, 0, 0, '0, '0, '0);
        set_req(1, 0, 0, '0, '0, '0);
        mem_rvalid_i = 2'b11; mem_rdata_i[0] = 64'hAAAA; mem_rdata_i[1] = 64'hBBBB;
        #2;
        chk("par rvalid_o", 64'(rvalid_o), 64'd3);
        chk("par rdata_o[0]", rdata_o[0], 64'hAAAA);
        chk("par rdata_o[1]", rdata_o[1], 64'hBBBB);
        cyc();
        mem_rvalid_i = '0;

        // backpressure: pointer points at requester 1, so it must stay the winner
        mem_gnt_i = 2'b00;
        set_req(0, 1, 1, 48'h7800_0300, 64'h11, 8'hFF);
        set_req(1, 1, 1, 48'h7800_0400, 64'h22, 8'h0F);
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("bp%0d mem_req_o[0]", c), 64'(mem_req_o[0]), 64'd1);
            chk($sformatf("bp%0d mem_addr_o[0]", c), 64'(mem_addr_o[0]), 64'h400);
            chk($sformatf("bp%0d mem_wdata_o[0]", c), mem_wdata_o[0], 64'h22);
            chk($sformatf("bp%0d gnt_o", c), 64'(gnt_o), 64'd0);
            cyc();
        end
        mem_gnt_i = 2'b01;
        #2;
        chk("bp release gnt_o", 64'(gnt_o), 64'd2);
        cyc();
        set_req(1, 0, 0, '0, '0, '0);
        #2;
        chk("bp second gnt_o", 64'(gnt_o), 64'd1);
        chk("bp second mem_addr_o[0]", 64'(mem_addr_o[0]), 64'h300);
        cyc();
        set_req(0, 0, 0, '0, '0, '0);
        mem_rvalid_i[0] = 1'b1; mem_rdata_i[0] = 64'h5555;
        #2;
        chk("bp first rsp rvalid_o", 64'(rvalid_o), 64'd2);
        chk("bp first rsp rdata_o[1]", rdata_o[1], 64'h5555);
        cyc();
        mem_rdata_i[0] = 64'h6666;
        #2;
        chk("bp second rsp rvalid_o", 64'(rvalid_o), 64'd1);
        chk("bp second rsp rdata_o[0]", rdata_o[0], 64'h6666);
        cyc();
        mem_rvalid_i = '0;

        // reset while waiting on port 0
        mem_gnt_i = 2'b11;
        set_req(0, 1, 0, 48'h7800_0500, '0, '0);
        #2;
        chk("rst pre gnt_o", 64'(gnt_o), 64'd1);
        cyc();
        set_req(0, 0, 0, '0, '0, '0);
        rst_i = 1'b1;
        set_req(1, 1, 0, 48'h7800_0700, '0, '0);
        #2;
        chk("in reset gnt_o", 64'(gnt_o), 64'd0);
        chk("in reset mem_req_o", 64'(mem_req_o), 64'd0);
        cyc();
        rst_i = 1'b0;
        set_req(1, 0, 0, '0, '0, '0);
        mem_rvalid_i[0] = 1'b1; mem_rdata_i[0] = 64'hBAD;
        #2;
        chk("dropped rvalid_o", 64'(rvalid_o), 64'd0);
        cyc();
        mem_rvalid_i = '0;
        set_req(0, 1, 0, 48'h7800_0600, '0, '0);
        #2;
        chk("post rst gnt_o", 64'(gnt_o), 64'd1);
        chk("post rst mem_addr_o[0]", 64'(mem_addr_o[0]), 64'h600);
        cyc();
        set_req(0, 0, 0, '0, '0, '0);
        cyc();
        mem_rvalid_i[0] = 1'b1; mem_rdata_i[0] = 64'h7777;
        #2;
        chk("post rst rvalid_o", 64'(rvalid_o), 64'd1);
        chk("post rst rdata_o[0]", rdata_o[0], 64'h7777);
        cyc();
        mem_rvalid_i = '0;
        cyc();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
